// File: rtl/hwt_pkg.sv
// Shared definitions for the hardware truth-table scan controller.
//   state_t        : scan controller FSM states
//   VEC_W / TBL_W  : swept input vector width and truth-table width
//   SETTLE_DEFAULT : default number of cycles each vector is held
package hwt_pkg;

  localparam int VEC_W          = 4;
  localparam int TBL_W          = 16;
  localparam int SETTLE_DEFAULT = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/hwt.sv
// Swept datapath: the combinational function under test.
//   vec : input vector {D,C,B,A}
//   y   : function output, high for vectors 11..14
module hwt
  import hwt_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             y
);

  logic a, b, c, d;

  assign {d, c, b, a} = vec;

  // 1011 | 1100 | 1101 | 1110
  assign y = (d & c & ~(b & a)) | (d & ~c & b & a);

endmodule

// File: rtl/hwt_scan_ctrl.sv
// Scan controller: sweeps all 16 input vectors through hwt, holding each
// for SETTLE cycles, captures Y per vector and compares it against a
// golden truth table latched at start.
//   clk, rst_n       : clock, asynchronous active-low reset
//   start, abort     : sweep request / sweep termination
//   golden           : expected truth table (bit i = expected Y for vector i)
//   busy, done, pass : sweep in progress / completion pulse / clean result
//   resp, mismatch   : captured Y per vector / resp XOR latched golden
//   fail_count       : number of mismatching vectors (0..16)
module hwt_scan_ctrl
  import hwt_pkg::*;
#(
  parameter int SETTLE = SETTLE_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [TBL_W-1:0] golden,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [TBL_W-1:0] resp,
  output logic [TBL_W-1:0] mismatch,
  output logic [4:0]       fail_count
);

  localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE - 1);
  localparam logic [4:0]       FAIL_MAX    = 5'(TBL_W);
  localparam logic [VEC_W-1:0] IDX_LAST    = '1;

  state_t           state, state_d;
  logic [VEC_W-1:0] idx, idx_d;
  logic [3:0]       cnt, cnt_d;
  logic [VEC_W-1:0] vec, vec_d;
  logic [TBL_W-1:0] golden_q, golden_d;
  logic [TBL_W-1:0] resp_d, mismatch_d;
  logic [4:0]       fail_d;
  logic             busy_d, done_d, pass_d;
  logic             y, miss;

  hwt u_hwt (
    .vec (vec),
    .y   (y)
  );

  assign miss = y ^ golden_q[idx];

  // Every register's next value is computed here; vec is registered too,
  // so hwt sees a clean, glitch-free vector that is zero outside a sweep.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d    = state;
    idx_d      = idx;
    cnt_d      = cnt;
    vec_d      = '0;
    golden_d   = golden_q;
    resp_d     = resp;
    mismatch_d = mismatch;
    fail_d     = fail_count;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    pass_d     = pass;

    unique case (state)
      ST_IDLE: begin
        // abort is irrelevant here, so start always wins
        if (start) begin
          golden_d   = golden;
          resp_d     = '0;
          mismatch_d = '0;
          fail_d     = '0;
          pass_d     = 1'b0;
          idx_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (abort) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
          vec_d  = idx;
          cnt_d  = cnt + 4'd1;
          if (cnt == SETTLE_LAST) state_d = ST_SAMPLE;
        end
      end

      ST_SAMPLE: begin
        if (abort) begin
          // partial results are left as they stand
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          resp_d[idx]     = y;
          mismatch_d[idx] = miss;
          if (miss && fail_count != FAIL_MAX) fail_d = fail_count + 5'd1;
          if (idx == IDX_LAST) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx + 4'd1;
            cnt_d   = '0;
            vec_d   = idx + 4'd1;
            busy_d  = 1'b1;
            state_d = ST_DRIVE;
          end
        end
      end

      ST_DONE: begin
        // fail_count already includes the last vector's sample
        done_d  = 1'b1;
        pass_d  = (fail_count == '0);
        state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt        <= '0;
      vec        <= '0;
      golden_q   <= '0;
      resp       <= '0;
      mismatch   <= '0;
      fail_count <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state      <= state_d;
      idx        <= idx_d;
      cnt        <= cnt_d;
      vec        <= vec_d;
      golden_q   <= golden_d;
      resp       <= resp_d;
      mismatch   <= mismatch_d;
      fail_count <= fail_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
    end
  end

endmodule

// File: tb/tb_hwt_scan_ctrl.sv
// Randomised scoreboard bench for hwt_scan_ctrl. Stimulus pushes the
// golden table and accept cycle of every sweep expected to complete; a
// monitor pops and checks on each done pulse against a truth-table model.
module tb_hwt_scan_ctrl;

  localparam int S   = 2;
  localparam int LAT = 16 * (S + 1) + 1;

  typedef struct {
    logic [15:0] g;
    int          accept;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] golden;
  logic        busy, done, pass;
  logic [15:0] resp, mismatch;
  logic [4:0]  fail_count;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;
  exp_t sb[$];

  hwt_scan_ctrl #(.SETTLE(S)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .abort      (abort),
    .golden     (golden),
    .busy       (busy),
    .done       (done),
    .pass       (pass),
    .resp       (resp),
    .mismatch   (mismatch),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the function under test is high for vectors 11..14.
  function automatic logic [15:0] ref_table();
    logic [15:0] t;
    for (int v = 0; v < 16; v++) t[v] = (v >= 11 && v <= 14);
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: every done pulse must match the oldest outstanding sweep.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [15:0] er, em;
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: done=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e  = sb.pop_front();
        er = ref_table();
        em = er ^ e.g;
        check("latency",    cyc - e.accept, LAT);
        check("resp",       resp, er);
        check("mismatch",   mismatch, em);
        check("fail_count", fail_count, $countones(em));
        check("pass",       pass, em == 16'h0);
      end
    end
  end

  // abort_c > 0: abort sampled on the abort_c-th edge after accept.
  task automatic run_sweep(input logic [15:0] g, input int abort_c, input bit disturb,
                           input bit abort_done, input bit with_abort);
    int          accept, n;
    logic [15:0] er, mask;
    @(negedge clk);
    golden = g;
    start  = 1'b1;
    abort  = with_abort;
    @(posedge clk);
    #1;
    start  = 1'b0;
    abort  = 1'b0;
    accept = cyc;
    check("busy_after_start", busy, 1'b1);
    if (abort_c > 0) begin
      repeat (abort_c - 1) @(posedge clk);
      #1 abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      n    = (abort_c - 1) / (S + 1);
      er   = ref_table();
      mask = 16'((32'd1 << n) - 1);
      check("abort_busy",     busy, 1'b0);
      check("abort_pass",     pass, 1'b0);
      check("abort_resp",     resp, er & mask);
      check("abort_mismatch", mismatch, (er ^ g) & mask);
      check("abort_fails",    fail_count, $countones((er ^ g) & mask));
      repeat (60) @(posedge clk);
      #1;
    end else begin
      sb.push_back('{g: g, accept: accept});
      if (disturb) begin
        repeat ($urandom_range(5, 40)) @(posedge clk);
        #1;
        golden = $urandom;
        start  = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_during_sweep", busy, 1'b1);
      end
      if (abort_done) begin
        while (cyc < accept + 48) begin
          @(posedge clk);
          #1;
        end
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
      for (int k = 0; k < 200 && sb.size() > 0; k++) @(posedge clk);
      #1;
      check("sweep_drain", sb.size(), 0);
      @(posedge clk);
      #1;
      check("pass_held", pass, (ref_table() ^ g) == 16'h0);
      check("busy_idle", busy, 1'b0);
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    start  = 1'b0;
    abort  = 1'b0;
    golden = '0;
    #12;
    check("rst_busy",     busy, 1'b0);
    check("rst_done",     done, 1'b0);
    check("rst_pass",     pass, 1'b0);
    check("rst_resp",     resp, 16'h0);
    check("rst_mismatch", mismatch, 16'h0);
    check("rst_fails",    fail_count, 5'd0);
    rst_n = 1'b1;

    run_sweep(16'h7800, 0, 1'b0, 1'b0, 1'b0);
    run_sweep(16'h7801, 0, 1'b0, 1'b0, 1'b0);
    run_sweep(16'h87FF, 0, 1'b0, 1'b0, 1'b0);
    run_sweep($urandom, 10, 1'b0, 1'b0, 1'b0);
    run_sweep(16'h7800, 0, 1'b1, 1'b0, 1'b0);
    run_sweep(16'h7800, 0, 1'b0, 1'b1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      logic [15:0] g;
      int          mode;
      g    = ($urandom_range(0, 2) == 0) ? 16'h7800 : 16'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        0: run_sweep(g, 0, 1'b0, 1'b0, 1'($urandom_range(0, 1)));
        1: run_sweep(g, 0, 1'b1, 1'b0, 1'b0);
        2: run_sweep(g, $urandom_range(1, 48), 1'b0, 1'b0, 1'b0);
        default: run_sweep(g, 0, 1'b1, 1'b1, 1'b0);
      endcase
    end

    // Asynchronous reset mid-sweep, released before the next edge.
    @(negedge clk);
    golden = $urandom;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (20) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("midrst_busy",     busy, 1'b0);
    check("midrst_done",     done, 1'b0);
    check("midrst_pass",     pass, 1'b0);
    check("midrst_resp",     resp, 16'h0);
    check("midrst_mismatch", mismatch, 16'h0);
    check("midrst_fails",    fail_count, 5'd0);
    check("midrst_vec",      dut.vec, 4'h0);
    check("midrst_state",    dut.state, 2'd0);
    sb.delete();
    rst_n = 1'b1;
    run_sweep(16'h7800, 0, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hwt_scan_ctrl.md
HWT_SCAN_CTRL -- requirements
Module: hwt_scan_ctrl

Interface
REQ-001 Parameter SETTLE, default 2, range 1..15: number of cycles each input vector is held before Y is sampled.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle request to begin a 16-vector sweep; honoured only in IDLE.
REQ-005 abort  input  1  terminates a sweep in progress.
REQ-006 golden  input  16  expected truth table; bit i is the expected Y for vector i = {D,C,B,A}.
REQ-007 busy  output  1  high from the cycle after start is accepted until the sweep ends.
REQ-008 done  output  1  one-cycle pulse marking sweep completion.
REQ-009 pass  output  1  high when the last completed sweep had no mismatches; held until the next start.
REQ-010 resp  output  16  captured Y per vector index.
REQ-011 mismatch  output  16  bit i = resp[i] XOR latched golden[i].
REQ-012 fail_count  output  5  population count of mismatch, range 0..16.

Function
REQ-013 States SHALL be IDLE, DRIVE, SAMPLE and DONE.
REQ-014 IDLE with start=1 SHALL:
  - latch golden;
  - clear resp, mismatch, fail_count and pass;
  - set vector index idx=0 and settle counter=0;
  - go to DRIVE.
REQ-015 In DRIVE, the block SHALL drive the hwt inputs with {D,C,B,A}=idx and increment the settle counter each cycle.
REQ-016 DRIVE SHALL go to SAMPLE when the settle counter reaches SETTLE-1.
REQ-017 In SAMPLE, the block SHALL:
  - write Y into resp[idx];
  - set mismatch[idx] from latched golden;
  - increment fail_count on a mismatch.
REQ-018 From SAMPLE, with idx<15: increment idx, clear the settle counter, go to DRIVE; with idx=15: go to DONE (no index wrap).
REQ-019 In DONE, the block SHALL:
  - assert done for exactly one cycle;
  - set pass=1 iff fail_count=0;
  - return to IDLE.
REQ-020 Sweep latency from the start-accept edge to the done pulse SHALL be exactly 16*(SETTLE+1)+1 cycles.
REQ-021 busy SHALL be high in DRIVE and SAMPLE and low in IDLE and DONE.
REQ-022 The golden input SHALL be ignored while busy; only the latched copy is compared.
REQ-023 start asserted while busy or in DONE SHALL be ignored (no queueing).
REQ-024 abort in DRIVE or SAMPLE SHALL cause:
  - next state IDLE;
  - no done pulse;
  - pass=0;
  - resp, mismatch and fail_count keep any partial values.
REQ-025 abort and start high together in IDLE: start SHALL win.
REQ-026 abort in DONE SHALL have no effect.
REQ-027 The hwt inputs SHALL be driven to 4'b0000 in IDLE and DONE.
REQ-028 fail_count SHALL saturate at 16 and never wrap.
REQ-029 All outputs SHALL be registered; there is no combinational path from any input to any output.

Reset
REQ-030 Assertion of rst_n=0 SHALL immediately force:
  - state IDLE;
  - busy=0, done=0, pass=0;
  - resp=0, mismatch=0, fail_count=0;
  - idx=0, settle counter=0;
  - hwt inputs = 0.
REQ-031 Reset asserted mid-sweep SHALL discard the sweep with no done pulse.
REQ-032 After deassertion, the block SHALL accept start on the first clock edge.

Structure
REQ-033 Shared package hwt_pkg SHALL hold:
  - the state enumeration;
  - vector width 4 and table width 16;
  - the default SETTLE constant.
REQ-034 The block SHALL instantiate exactly one sub-module, hwt, as the swept datapath.
REQ-035 No other sub-modules SHALL be used.

Verification
REQ-036 Reset release, start with golden=16'h7800, SETTLE=2 -> done 49 cycles after start accept, resp=16'h7800, mismatch=0, fail_count=0, pass=1.
REQ-037 golden=16'h7801 -> resp=16'h7800, mismatch=16'h0001, fail_count=1, pass=0.
REQ-038 golden=16'h87FF -> mismatch=16'hFFFF, fail_count=16 (no wrap), pass=0.
REQ-039 abort asserted 10 cycles into a sweep -> busy falls the next cycle, no done pulse, pass=0, start then accepted normally.
REQ-040 start pulsed again while busy, and golden changed mid-sweep -> no restart, results match the originally latched golden.
REQ-041 rst_n pulled low mid-sweep (asynchronously, between edges) -> all outputs 0 immediately, hwt inputs 0, state IDLE.
